// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: difference and borrow-out for a single bit position.
module full_subtractor_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bo
);

  assign o_d  = i_a ^ i_b ^ i_bin;
  assign o_bo = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single subtractor cell.
//   state    | meaning
//   ST_IDLE  | waiting for start; result registers hold the last answer
//   ST_SHIFT | one operand bit pair consumed per clock, WIDTH clocks total
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_bout;
  logic             r_done;
  logic             w_d;
  logic             w_bo;
  logic             w_accept;
  logic             w_last;

  full_subtractor_1bit u_cell (
    .i_a   (r_a[0]),
    .i_b   (r_b[0]),
    .i_bin (r_borrow),
    .o_d   (w_d),
    .o_bo  (w_bo)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a      <= i_a;
        r_b      <= i_b;
        r_borrow <= i_bin;
        r_cnt    <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_borrow <= w_bo;
        // Difference bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        r_work   <= {w_d, r_work[WIDTH-1:1]};
        if (w_last) begin
          r_diff <= {w_d, r_work[WIDTH-1:1]};
          r_bout <= w_bo;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_busy = (r_state == ST_SHIFT);
  assign o_done = r_done;
  assign o_diff = r_diff;
  assign o_bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         bin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic         bout;
  logic [W-1:0] diff;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_diff  (diff),
    .o_bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {bout,diff} is the (W+1)-bit two's-complement of a - b - bin.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    return r;
  endfunction

  task automatic wait_done(input int max_cyc, output int lat);
    logic [W-1:0] hd;
    logic         hb;
    hd  = diff;
    hb  = bout;
    lat = 0;
    while (lat < max_cyc) begin
      step();
      lat++;
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) break;
      chk("diff_hold", {24'd0, diff}, {24'd0, hd});
      chk("bout_hold", {31'd0, bout}, {31'd0, hb});
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a     = x;
    b     = y;
    bin   = c;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic c);
    logic [W:0] e;
    e = ref_sub(x, y, c);
    chk({tag, "_diff"}, {24'd0, diff}, {24'd0, e[W-1:0]});
    chk({tag, "_bout"}, {31'd0, bout}, {31'd0, e[W]});
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c);
    int lat;
    start_op(x, y, c);
    wait_done(3 * W, lat);
    chk({tag, "_latency"}, lat, W);
    check_result(tag, x, y, c);
    step();
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int         lat;
    int         lat2;
    int         gap;
    logic       saw_done;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic       rc;

    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    step();
    rst_n = 1'b1;

    do_op("sub_5_3", 8'h05, 8'h03, 1'b0);
    do_op("sub_3_5", 8'h03, 8'h05, 1'b0);
    do_op("sub_0_0_b", 8'h00, 8'h00, 1'b1);
    do_op("sub_0_0", 8'h00, 8'h00, 1'b0);
    do_op("sub_ff_ff_b", 8'hFF, 8'hFF, 1'b1);
    do_op("sub_80_7f", 8'h80, 8'h7F, 1'b0);

    // Start held high through done: second op accepted on the done cycle.
    a     = 8'hFF;
    b     = 8'h00;
    bin   = 1'b0;
    start = 1'b1;
    step();
    a   = 8'h12;
    b   = 8'h34;
    bin = 1'b1;
    wait_done(3 * W, lat);
    chk("b2b_first_latency", lat, W);
    check_result("b2b_first", 8'hFF, 8'h00, 1'b0);
    wait_done(3 * W, lat2);
    start = 1'b0;
    chk("b2b_second_spacing", lat2, W + 1);
    check_result("b2b_second", 8'h12, 8'h34, 1'b1);
    step();
    chk("b2b_no_third", {31'd0, busy}, 32'd0);

    // Start re-pulsed mid-shift is ignored.
    start_op(8'h5A, 8'h33, 1'b0);
    step();
    step();
    a     = 8'h10;
    b     = 8'h01;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ignore_busy", {31'd0, busy}, 32'd1);
    wait_done(3 * W, lat);
    chk("ignore_latency", lat + 3, W);
    check_result("ignore", 8'h5A, 8'h33, 1'b0);
    step();

    // Reset mid-shift aborts without a done pulse.
    start_op(8'hC3, 8'h21, 1'b1);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_diff", {24'd0, diff}, 32'd0);
    chk("abort_bout", {31'd0, bout}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    step();
    step();
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      saw_done |= done;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    do_op("after_abort", 8'h9C, 8'h4D, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      rx = W'($urandom);
      ry = W'($urandom);
      rc = 1'($urandom);
      do_op("rand", rx, ry, rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request: capture operands and begin subtraction; honoured only in IDLE.
REQ-005 a  input  WIDTH  minuend, sampled on accepted start.
REQ-006 b  input  WIDTH  subtrahend, sampled on accepted start.
REQ-007 bin  input  1  borrow-in, sampled on accepted start.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  one-cycle pulse: result registers updated.
REQ-010 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Function
REQ-012 Bit-serial, LSB first; exactly one bit processed per clock through a single 1-bit full-subtractor cell.
REQ-013 Cell equations: d = a ^ b ^ br; bo = (~a & b) | (~(a ^ b) & br).
REQ-014 States: IDLE, SHIFT; no other states.
REQ-015 IDLE + start=1 at edge k: latch a, b into shift registers, bin into borrow flop, clear bit counter, go to SHIFT; busy=1 after edge k.
REQ-016 SHIFT: edges k+1..k+WIDTH process bits 0..WIDTH-1; borrow flop takes bo each edge; difference bit shifts into working register MSB side.
REQ-017 At edge k+WIDTH: diff <= working result, bout <= final borrow, done=1 for that cycle only, busy=0, state IDLE.
REQ-018 Latency start-accept to done: WIDTH cycles; throughput one operation per WIDTH+1 cycles minimum (start may be accepted the cycle done is high, since state is IDLE).
REQ-019 start while busy=1 is ignored; operands and in-flight computation unaffected.
REQ-020 a, b, bin changes after the accepting edge do not affect the result.
REQ-021 diff and bout hold their last value until the next done; they do not change during SHIFT.
REQ-022 Bit counter width $clog2(WIDTH); terminal count WIDTH-1; no wrap beyond it.
REQ-023 busy and done are never high in the same cycle.

Reset
REQ-024 rst_n=0 asynchronously forces: state IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow flop=0, shift registers=0.
REQ-025 Reset mid-SHIFT aborts the operation; no done pulse is generated for it.
REQ-026 First start is accepted on the first rising edge with rst_n=1 and start=1.

Structure
REQ-027 Shared package holds: state enum (IDLE, SHIFT) and default WIDTH constant.
REQ-028 One sub-module: full_subtractor_1bit (inputs a, b, bin; outputs d, bo), purely combinational, instantiated once.
REQ-029 All remaining logic (FSM, counter, shift and result registers) lives in serial_subtractor.

Verification (WIDTH=8)
REQ-030 a=0x05, b=0x03, bin=0, start pulse -> done exactly 8 cycles after accept, diff=0x02, bout=0.
REQ-031 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-032 a=0xFF, b=0x00, bin=0 followed by start held high through done -> diff=0xFF, bout=0; second op accepted on done cycle, its done 9 cycles after first done.
REQ-033 start re-pulsed with a=0x10, b=0x01 at cycle 3 of SHIFT -> ignored; original result and timing unchanged.
REQ-034 rst_n low at cycle 4 of SHIFT -> busy=0, diff=0, bout=0 immediately; no done; next start computes correctly.
REQ-035 Random a, b, bin (>=1000 ops, random start gaps) vs. reference model {bout,diff} = a - b - bin.
